pulse_gen_arbiter: RTL

- Shares one pulse_gen instance between NREQ requesters.
- Each requester asks for a burst of N pulses at a given freq setting.
- The arbiter grants the generator round-robin and drives its num/freq configuration and enable.
- It counts the returned pulses to detect burst completion, then reports done or timeout per requester.

---
 rtl/pulse_gen_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pulse_gen_arbiter.sv
// pulse_gen_arbiter
//   Shares one pulse generator between NREQ requesters. Each requester asks
//   for a burst of N pulses at its own freq setting; the arbiter grants the
//   generator round-robin, drives its num/freq/enable, counts the returned
//   rising edges to detect burst completion and reports done (or done+err on
//   a watchdog timeout) back to the granted requester.
//
// Ports
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   req       per-requester level request, held until done/err
//   req_num   per-requester pulse count, slice i = [i*NUM_W +: NUM_W]
//   req_freq  per-requester freq setting, slice i = [i*FREQ_W +: FREQ_W]
//   gnt       one-hot grant, held through LOAD and RUN
//   done      one-cycle completion strobe to the granted requester
//   err       one-cycle strobe with done when the watchdog expired
//   busy      high whenever the arbiter is not idle
//   pg_en     pulse generator enable (RUN only)
//   pg_num    num latched for the current burst
//   pg_freq   freq latched for the current burst
//   pg_pulse  pulse output returned from the generator
module pulse_gen_arbiter #(
    parameter int NREQ   = 4,
    parameter int NUM_W  = 8,
    parameter int FREQ_W = 4,
    parameter int TO_W   = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*NUM_W-1:0]    req_num,
    input  logic [NREQ*FREQ_W-1:0]   req_freq,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic                     busy,
    output logic                     pg_en,
    output logic [NUM_W-1:0]         pg_num,
    output logic [FREQ_W-1:0]        pg_freq,
    input  logic                     pg_pulse
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       ptr_reg, ptr_next;
    logic [IW-1:0]       win_reg, win_next;
    logic [NUM_W-1:0]    cnt_reg, cnt_next;
    logic [NUM_W-1:0]    pg_num_reg, pg_num_next;
    logic [FREQ_W-1:0]   pg_freq_reg, pg_freq_next;
    logic [TO_W-1:0]     wdog_reg, wdog_next;
    logic                err_reg, err_next;
    logic                pulse_q_reg;

    logic [NUM_W-1:0]    num_arr  [NREQ];
    logic [FREQ_W-1:0]   freq_arr [NREQ];
    logic                found;
    logic [IW-1:0]       pick;
    logic                pulse_edge;
    logic [NUM_W-1:0]    cnt_inc;
    logic [TO_W-1:0]     wdog_inc;
    logic [NREQ-1:0]     win_onehot;

    // Unpack the flat request buses into per-requester fields.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign num_arr[gi]  = req_num[gi*NUM_W +: NUM_W];
            assign freq_arr[gi] = req_freq[gi*FREQ_W +: FREQ_W];
        end
    endgenerate

    // (base + k) wrapped into 0..NREQ-1 without a general modulo.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Round-robin search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[rr_idx(ptr_reg, k)]) begin
                found = 1'b1;
                pick  = rr_idx(ptr_reg, k);
            end
        end
    end

    // The edge register follows pg_pulse every cycle, so a pulse that is
    // already high when RUN begins is seen as "no edge" and never counted.
    assign pulse_edge = (state_reg == S_RUN) && pg_pulse && !pulse_q_reg;
    assign cnt_inc    = cnt_reg + NUM_W'(1);
    assign wdog_inc   = wdog_reg + TO_W'(1);

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        win_next     = win_reg;
        cnt_next     = cnt_reg;
        wdog_next    = wdog_reg;
        err_next     = err_reg;
        pg_num_next  = pg_num_reg;
        pg_freq_next = pg_freq_reg;
        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    win_next     = pick;
                    pg_num_next  = num_arr[pick];
                    pg_freq_next = freq_arr[pick];
                    cnt_next     = '0;
                    wdog_next    = '0;
                    err_next     = 1'b0;
                    state_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_next  = '0;
                wdog_next = '0;
                // A zero-length burst completes without ever enabling the generator.
                state_next = (pg_num_reg == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (!req[win_reg]) begin
                    // Requester withdrew: silent abort, pointer untouched.
                    state_next = S_IDLE;
                end else if (pulse_edge) begin
                    // An edge always counts as progress, even on the cycle
                    // the watchdog would otherwise have expired.
                    cnt_next  = cnt_inc;
                    wdog_next = '0;
                    if (cnt_inc == pg_num_reg) state_next = S_DONE;
                end else begin
                    wdog_next = wdog_inc;
                    if (wdog_inc == '1) begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ptr_next   = (win_reg == LAST_IDX) ? '0 : win_reg + IW'(1);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            ptr_reg     <= '0;
            win_reg     <= '0;
            cnt_reg     <= '0;
            wdog_reg    <= '0;
            err_reg     <= 1'b0;
            pg_num_reg  <= '0;
            pg_freq_reg <= '0;
            pulse_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            win_reg     <= win_next;
            cnt_reg     <= cnt_next;
            wdog_reg    <= wdog_next;
            err_reg     <= err_next;
            pg_num_reg  <= pg_num_next;
            pg_freq_reg <= pg_freq_next;
            pulse_q_reg <= pg_pulse;
        end
    end

    // Outputs decode straight from the state register, so reset clears them
    // (including pg_en) without waiting for a clock edge.
    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_reg;
    assign busy    = (state_reg != S_IDLE);
    assign pg_en   = (state_reg == S_RUN);
    assign gnt     = ((state_reg == S_LOAD) || (state_reg == S_RUN)) ? win_onehot : '0;
    assign done    = (state_reg == S_DONE) ? win_onehot : '0;
    assign err     = (state_reg == S_DONE) && err_reg;
    assign pg_num  = pg_num_reg;
    assign pg_freq = pg_freq_reg;

endmodule
